// File: rtl/j0_bus_arb.sv
// Arbitrates the single-port coprocessor data RAM between the host port and the j0 core.
// Host wins. j0 is paused for the host access and a recovery window, and it is held in reset while run_en is low.
module j0_bus_arb #(
  parameter int HOLD_CYCLES = 2,
  parameter int MIN_RUN     = 1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        run_en,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  input  logic [15:0] j0_mem_addr,
  input  logic        j0_mem_wr,
  input  logic [15:0] j0_mem_dout,
  output logic [15:0] j0_mem_din,
  output logic        j0_pause,
  output logic        j0_rst,
  output logic [15:0] mem_addr,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Host handshake: host_req is a level that stays high until the one-cycle host_ack.
  // host_wr, host_addr and host_wdata must remain stable over that whole interval.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    DATA    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [4:0] MIN_RUN_L = 5'(MIN_RUN);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] run_cnt, run_cnt_nxt;
  logic [3:0] hold_cnt, hold_cnt_nxt;

  always_comb begin
    state_nxt    = state;
    run_cnt_nxt  = run_cnt;
    hold_cnt_nxt = hold_cnt;
    mem_addr     = j0_mem_addr;
    mem_wr       = 1'b0;
    mem_wdata    = j0_mem_dout;
    case (state)
      IDLE: begin
        mem_wr = j0_mem_wr;
        if (run_cnt != 4'hF) run_cnt_nxt = run_cnt + 4'd1;
        // A j0 held in reset gains nothing from a run window, so it cannot delay the host.
        if (host_req && ((({1'b0, run_cnt} + 5'd1) >= MIN_RUN_L) || j0_rst))
          state_nxt = GRANT;
      end
      GRANT: begin
        mem_addr  = host_addr;
        mem_wr    = host_wr;
        mem_wdata = host_wdata;
        state_nxt = DATA;
      end
      DATA: begin
        mem_addr     = host_addr;
        mem_wdata    = host_wdata;
        state_nxt    = RECOVER;
        hold_cnt_nxt = 4'd0;
      end
      RECOVER: begin
        // j0's pending address is driven to the RAM here, so its first read after resuming is valid.
        if (hold_cnt == HOLD_LAST) begin
          state_nxt   = IDLE;
          run_cnt_nxt = 4'd0;
        end else begin
          hold_cnt_nxt = hold_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (sys_rst_i) mem_wr = 1'b0;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state      <= IDLE;
      run_cnt    <= 4'd0;
      hold_cnt   <= 4'd0;
      j0_pause   <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= 16'd0;
      j0_rst     <= 1'b1;
    end else begin
      state    <= state_nxt;
      run_cnt  <= run_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
      j0_pause <= (state_nxt != IDLE);
      host_ack <= (state == DATA);
      j0_rst   <= ~run_en;
      if (state == DATA && !host_wr) host_rdata <= mem_rdata;
    end
  end

  assign j0_mem_din = mem_rdata;
  assign dbg_state  = state;

endmodule

// File: doc/j0_bus_arb.md
Name: j0_bus_arb

Overview:
- Shares the single-port coprocessor data RAM between the host port (SPI/register side) and the j0 core.
- The host has priority. The block stalls j0 via its pause input, performs the host access, then keeps j0 paused for a recovery window so j0's pending address reaches the RAM before j0 resumes.
- Also generates j0's synchronous reset from the run-enable control bit.
- Enforces a minimum j0 run window between host grants.

Parameters:
- HOLD_CYCLES, 2, recovery cycles of j0 pause after each host access (legal range 1..15).
- MIN_RUN, 1, minimum consecutive IDLE cycles granted to a running j0 before the next host grant (legal range 1..15).

Ports:
- sys_clk_i in 1: clock.
- sys_rst_i in 1: synchronous reset, active-high.
- run_en in 1: j0 run enable, from the control register.
- host_req in 1: host request, level; held until host_ack.
- host_wr in 1: 1 = write, 0 = read; valid with host_req.
- host_addr in 16: host address.
- host_wdata in 16: host write data.
- host_ack out 1: one-cycle completion pulse.
- host_rdata out 16: read data, valid from host_ack until the next read completes.
- j0_mem_addr in 16: j0 address (j0 mem_addr).
- j0_mem_wr in 1: j0 write strobe (already gated by j0 pause).
- j0_mem_dout in 16: j0 write data.
- j0_mem_din out 16: read data to j0.
- j0_pause out 1: stall to j0.
- j0_rst out 1: reset to j0.
- mem_addr out 16: RAM address.
- mem_wr out 1: RAM write enable.
- mem_wdata out 16: RAM write data.
- mem_rdata in 16: RAM read data; one-cycle latency from mem_addr.

Behaviour:
- Reset (sys_rst_i=1 at a clock edge): state=IDLE, j0_pause=0, host_ack=0, host_rdata=0, run counter=0, hold counter=0, j0_rst=1. While sys_rst_i is high, mem_wr is forced to 0 combinationally.
- j0_rst is a register: j0_rst <= sys_rst_i | ~run_en. The run_en edge reaches j0_rst one cycle later.
- j0_mem_din = mem_rdata at all times.
- j0_pause is a registered output, high in the GRANT, DATA and RECOVER states only. There is no combinational path from host_req to j0_pause.
- IDLE:
  - Mux selects j0: mem_addr=j0_mem_addr, mem_wr=j0_mem_wr, mem_wdata=j0_mem_dout.
  - run counter increments, saturating at 15.
  - Go to GRANT when host_req=1 and (run counter+1 >= MIN_RUN, or j0_rst=1).
  - The IDLE cycle in which host_req is sampled is a normal j0 cycle.
- GRANT, 1 cycle: mem_addr=host_addr, mem_wr=host_wr, mem_wdata=host_wdata. Go to DATA.
- DATA, 1 cycle: mem_addr=host_addr, mem_wr=0. Capture host_rdata <= mem_rdata only if host_wr=0. Go to RECOVER with hold counter=0.
- RECOVER:
  - host_ack=1 in the first RECOVER cycle only.
  - mem_addr=j0_mem_addr, mem_wr=0.
  - After HOLD_CYCLES cycles, go to IDLE with run counter=0.
- Latency: host_req first sampled high at edge T gives GRANT in T+1, DATA in T+2, host_ack in T+3. j0 resumes at T+3+HOLD_CYCLES.
- Host must deassert host_req on the cycle after host_ack. If host_req is high again when back in IDLE, it is a new transaction, subject to MIN_RUN.
- host_wr, host_addr and host_wdata must be stable from request until ack. The block samples them in GRANT/DATA.
- Requests during j0 reset (j0_rst=1) ignore MIN_RUN.
- sys_rst_i asserted in any state aborts the transaction with no ack; a write already issued in GRANT stays written. The host must retry.
- run_en changes mid-transaction do not alter the state sequence.
- Saturating counters: the run counter stays at 15 once reached; no wrap.

Test Plan:
1. Host write, j0 in reset (run_en=0), host_addr=0x0010, host_wdata=0xBEEF, req at edge T -> mem_wr=1 with mem_addr=0x0010 in cycle T+1 only; host_ack pulse at T+3; j0_pause high T+1..T+4 (HOLD_CYCLES=2).
2. Host read of 0x0010 after scenario 1 -> host_rdata=0xBEEF from the ack cycle onward; mem_wr stays 0 throughout.
3. j0 running with j0_mem_wr=1 at 0x0020 every cycle, host read requested -> j0 write is visible on the mem port in the sampling IDLE cycle; suppressed in GRANT, DATA and RECOVER; mem_addr=j0_mem_addr during RECOVER.
4. MIN_RUN=3, host_req held across two transactions, j0 running -> at least 3 IDLE cycles with j0_pause=0 between the first ack's RECOVER and the second GRANT; with run_en=0, only 1 IDLE cycle.
5. sys_rst_i pulsed during DATA -> no host_ack; next cycle state is IDLE, j0_pause=0, j0_rst=1, host_rdata=0.
6. run_en 0->1 at edge T -> j0_rst falls at T+1; host access then behaves as in scenario 3.
